// File: rtl/mp_regfile_if.sv
// Bus bundle for mp_regfile: read, writeback, issue and flush signals plus busy outputs.
// The master side drives addresses/commands; the slave side is the register file.
interface mp_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        iss_en;
    logic [NUM_WR*ADDR_W-1:0] iss_addr;
    logic                     flush;
    logic [(2**ADDR_W)-1:0]   busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/mp_regfile.sv
// Multi-ported register file with a busy scoreboard; register 0 is hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module mp_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic          clk,
    input  logic          rst,
    mp_regfile_if.slave   bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   r_busy;

    logic [NREG-1:0]   w_busy_nxt;
    logic [ADDR_W-1:0] w_rd_addr  [NUM_RD];
    logic [DATA_W-1:0] w_rd_val   [NUM_RD];
    logic [NUM_RD-1:0] w_rd_bsy;
    logic [ADDR_W-1:0] w_wr_addr  [NUM_WR];
    logic [DATA_W-1:0] w_wr_data  [NUM_WR];
    logic [ADDR_W-1:0] w_iss_addr [NUM_WR];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign w_rd_addr[k]                      = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign bus.rd_data[k*DATA_W +: DATA_W]   = w_rd_val[k];
    end

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign w_wr_addr[p]  = bus.wr_addr[p*ADDR_W +: ADDR_W];
        assign w_wr_data[p]  = bus.wr_data[p*DATA_W +: DATA_W];
        assign w_iss_addr[p] = bus.iss_addr[p*ADDR_W +: ADDR_W];
    end

    // Priority: writeback clears, then issue sets, then flush clears everything.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p]) begin
                w_busy_nxt[w_wr_addr[p]] = 1'b0;
            end
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (bus.iss_en[p]) begin
                w_busy_nxt[w_iss_addr[p]] = 1'b1;
            end
        end
        if (bus.flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Later ports are assigned last in the loop, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            for (int p = 0; p < NUM_WR; p++) begin
                if (bus.wr_en[p] && (w_wr_addr[p] != '0)) begin
                    r_mem[w_wr_addr[p]] <= w_wr_data[p];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_val[k] = '0;
            w_rd_bsy[k] = 1'b0;
            if (w_rd_addr[k] != '0) begin
                w_rd_val[k] = r_mem[w_rd_addr[k]];
                w_rd_bsy[k] = r_busy[w_rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en[p] && (w_wr_addr[p] == w_rd_addr[k])) begin
                        w_rd_val[k] = w_wr_data[p];
                        w_rd_bsy[k] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_busy  = w_rd_bsy;
    assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_mp_regfile.sv
// Directed bench for mp_regfile: reset sweep, a vector table of single-cycle commands,
// and hand-written multi-cycle sequences (issue/writeback timing, bypass, mid-run reset).
module tb_mp_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mp_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2)) bus ();

    mp_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  ie;
        logic [4:0]  ia0, ia1;
        logic        fl;
        logic [4:0]  ra0, ra1, ra2, ra3;
        logic [31:0] e0, e1, e2, e3;
        logic [31:0] ebv;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic vec_t mk(input string n, input logic [1:0] we,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [1:0] ie, input logic [4:0] ia0, input logic [4:0] ia1,
                                input logic fl,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [4:0] ra2, input logic [4:0] ra3,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3,
                                input logic [31:0] ebv);
        vec_t v;
        v.name = n; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ia0 = ia0; v.ia1 = ia1; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.ebv = ebv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdk(input int k);
        return bus.rd_data[k*32 +: 32];
    endfunction

    task automatic idle();
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = '0; bus.iss_addr = '0; bus.flush = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        bus.rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic cmd(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [1:0] ie, input logic [4:0] ia0, input logic [4:0] ia1,
                       input logic fl);
        bus.wr_en = we; bus.wr_addr = {wa1, wa0}; bus.wr_data = {wd1, wd0};
        bus.iss_en = ie; bus.iss_addr = {ia1, ia0}; bus.flush = fl;
    endtask

    // Clock the current command in, then return to idle 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic chk_reads(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input logic [31:0] ebv);
        logic [4:0] a [4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        set_rd(a0, a1, a2, a3);
        #1;
        chk({tag, "_rd0"}, rdk(0), e0);
        chk({tag, "_rd1"}, rdk(1), e1);
        chk({tag, "_rd2"}, rdk(2), e2);
        chk({tag, "_rd3"}, rdk(3), e3);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_rdbusy%0d", tag, k), {31'b0, bus.rd_busy[k]}, {31'b0, ebv[a[k]]});
        end
        chk({tag, "_busy_vec"}, bus.busy_vec, ebv);
    endtask

    initial begin
        vecs[0] = mk("dual_r5",   2'b11, 5'd5, 32'h11111111, 5'd5, 32'h22222222, 2'b00, 5'd0, 5'd0, 1'b0,
                     5'd5, 5'd0, 5'd1, 5'd2, 32'h22222222, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk("distinct",  2'b11, 5'd1, 32'hAAAA0001, 5'd2, 32'hBBBB0002, 2'b00, 5'd0, 5'd0, 1'b0,
                     5'd1, 5'd2, 5'd5, 5'd3, 32'hAAAA0001, 32'hBBBB0002, 32'h22222222, 32'h0, 32'h0);
        vecs[2] = mk("r0_wr_iss", 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0,
                     5'd0, 5'd1, 5'd2, 5'd5, 32'h0, 32'hAAAA0001, 32'hBBBB0002, 32'h22222222, 32'h0);
        vecs[3] = mk("iss_3_4",   2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 1'b0,
                     5'd3, 5'd4, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'h22222222, 32'h18);
        vecs[4] = mk("flush",     2'b01, 5'd3, 32'h5, 5'd0, 32'h0, 2'b01, 5'd6, 5'd0, 1'b1,
                     5'd3, 5'd4, 5'd6, 5'd0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk("iss_8_10",  2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd8, 5'd10, 1'b0,
                     5'd8, 5'd10, 5'd3, 5'd1, 32'h0, 32'h0, 32'h5, 32'hAAAA0001, 32'h500);
        vecs[6] = mk("wb_8",      2'b01, 5'd8, 32'h88, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0,
                     5'd8, 5'd10, 5'd0, 5'd2, 32'h88, 32'h0, 32'h0, 32'hBBBB0002, 32'h400);
        vecs[7] = mk("set_wins",  2'b10, 5'd0, 32'h0, 5'd10, 32'h1010, 2'b01, 5'd10, 5'd0, 1'b0,
                     5'd10, 5'd8, 5'd0, 5'd5, 32'h1010, 32'h88, 32'h0, 32'h22222222, 32'h400);
        vecs[8] = mk("wb_10_r31", 2'b11, 5'd10, 32'h1011, 5'd31, 32'hFFFFFFFF, 2'b00, 5'd0, 5'd0, 1'b0,
                     5'd10, 5'd31, 5'd8, 5'd0, 32'h1011, 32'hFFFFFFFF, 32'h88, 32'h0, 32'h0);
        vecs[9] = mk("iss_12dup", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd12, 5'd12, 1'b0,
                     5'd12, 5'd31, 5'd3, 5'd9, 32'h0, 32'hFFFFFFFF, 32'h5, 32'h0, 32'h1000);

        // Reset with commands active: they must be ignored.
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        cmd(2'b11, 5'd3, 32'h33333333, 5'd4, 32'h44444444, 2'b11, 5'd3, 5'd4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        step();
        rst = 1'b0;
        for (int g = 0; g < 8; g++) begin
            chk_reads($sformatf("reset_g%0d", g), 5'(4*g), 5'(4*g+1), 5'(4*g+2), 5'(4*g+3),
                      32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            cmd(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                vecs[i].ie, vecs[i].ia0, vecs[i].ia1, vecs[i].fl);
            step();
            chk_reads(vecs[i].name, vecs[i].ra0, vecs[i].ra1, vecs[i].ra2, vecs[i].ra3,
                      vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].ebv);
        end

        // Issue r7 at N, writeback plus re-issue at N+3: busy stays high, data lands at N+4.
        cmd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0);
        step();
        chk_reads("r7_n1", 5'd7, 5'd0, 5'd12, 5'd3, 32'h0, 32'h0, 32'h0, 32'h5, 32'h1080);
        step();
        chk_reads("r7_n2", 5'd7, 5'd0, 5'd12, 5'd3, 32'h0, 32'h0, 32'h0, 32'h5, 32'h1080);
        step();
        chk_reads("r7_n3", 5'd7, 5'd0, 5'd12, 5'd3, 32'h0, 32'h0, 32'h0, 32'h5, 32'h1080);
        cmd(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 2'b10, 5'd0, 5'd7, 1'b0);
        step();
        chk_reads("r7_n4", 5'd7, 5'd0, 5'd12, 5'd3, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h5, 32'h1080);

        // Same-cycle read of a register being written.
        cmd(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0);
        step();
        cmd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0);
        step();
        chk_reads("r9_busy", 5'd9, 5'd7, 5'd0, 5'd12, 32'h99, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h1280);
        cmd(2'b01, 5'd9, 32'h12345678, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0);
        set_rd(5'd9, 5'd0, 5'd7, 5'd12);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rdk(0), 32'h12345678);
        chk("byp_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
`else
        chk("byp_data", rdk(0), 32'h99);
        chk("byp_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
`endif
        chk("byp_other", rdk(2), 32'hA5A5A5A5);
        step();
        chk_reads("r9_wb", 5'd9, 5'd7, 5'd0, 5'd12, 32'h12345678, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h1080);
        cmd(2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 2'b00, 5'd0, 5'd0, 1'b0);
        set_rd(5'd9, 5'd0, 5'd7, 5'd12);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_tie", rdk(0), 32'h2);
`else
        chk("byp_tie", rdk(0), 32'h12345678);
`endif
        step();
        chk_reads("r9_tie", 5'd9, 5'd7, 5'd0, 5'd12, 32'h2, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h1080);

        // Reset mid-operation discards the same-cycle write and issue.
        cmd(2'b01, 5'd1, 32'h0000FFFF, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reads("mid_rst_a", 5'd1, 5'd2, 5'd7, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk_reads("mid_rst_b", 5'd31, 5'd10, 5'd5, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mp_regfile.md
MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; the register count is 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 4, meaning the number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 2, meaning the number of write ports and the number of issue (scoreboard-set) ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: read addresses, port k in slice k.
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_W bits: read data, port k in slice k.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD bits: bit k high when the register at rd_addr slice k has a pending producer.
REQ-010 The block SHALL have port wr_en, input, NUM_WR bits: per-port writeback enable.
REQ-011 The block SHALL have port wr_addr, input, NUM_WR*ADDR_W bits: writeback addresses.
REQ-012 The block SHALL have port wr_data, input, NUM_WR*DATA_W bits: writeback data.
REQ-013 The block SHALL have port iss_en, input, NUM_WR bits: per-port issue enable, which marks the destination busy.
REQ-014 The block SHALL have port iss_addr, input, NUM_WR*ADDR_W bits: issue destination addresses.
REQ-015 The block SHALL have port flush, input, 1 bit: clears all busy bits without touching data.
REQ-016 The block SHALL have port busy_vec, output, 2**ADDR_W bits: the registered busy bit of every register.

Function
REQ-017 The block SHALL hold register 0 constant at zero: writes to address 0 are ignored, reads of address 0 return 0, and busy bit 0 is never set.
REQ-018 Reads SHALL be combinational: rd_data slice k = array[rd_addr slice k], subject to REQ-017 and REQ-027.
REQ-019 Each enabled write port SHALL update array[wr_addr] with wr_data at the next rising edge.
REQ-020 When two or more enabled write ports target the same nonzero address in one cycle, the highest-indexed port SHALL win and the others SHALL be discarded.
REQ-021 Writes to distinct addresses in the same cycle SHALL all take effect in the same edge.
REQ-022 An enabled write port SHALL clear busy[wr_addr] at the next edge.
REQ-023 An enabled issue port SHALL set busy[iss_addr] at the next edge.
REQ-024 When an issue and a writeback target the same register in the same cycle, the set SHALL win: the busy bit ends high and the data is still written.
REQ-025 flush SHALL clear every busy bit at the next edge, overriding same-cycle issue sets; same-cycle writes to the data array still occur.
REQ-026 rd_busy bit k SHALL equal busy[rd_addr slice k] (registered state), subject to REQ-027.

Reset
REQ-028 While rst is high at a rising edge, all array entries and all busy bits SHALL become 0, and wr_en, iss_en and flush SHALL be ignored in that cycle.
REQ-029 After reset, every rd_data slice SHALL read 0, and rd_busy and busy_vec SHALL be all 0.
REQ-030 Reset asserted mid-operation SHALL discard same-cycle writes and issues, with no partial update.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read whose nonzero address matches an enabled write port in the same cycle SHALL return that port's wr_data (highest index on a tie), and its rd_busy SHALL read 0; without the macro, reads return the pre-edge array value and the registered busy bit.
REQ-031 The macro SHALL affect only the read path; the registered state is identical with and without it.

Verification
REQ-032 Reset, then read all 32 addresses on 4 ports -> every rd_data is 0 and busy_vec is 0.
REQ-033 Same cycle: port0 writes r5=0x11111111 and port1 writes r5=0x22222222 -> the next cycle, r5 reads 0x22222222.
REQ-034 Write r0=0xDEADBEEF and issue r0 -> r0 reads 0 and busy_vec[0]=0.
REQ-035 Issue r7 in cycle N; write r7=0xA5A5A5A5 and issue r7 again in cycle N+3 -> busy[7]=1 from N+1 onward; data is 0xA5A5A5A5 from N+4; busy[7] is still 1.
REQ-036 Read r9 in the same cycle as a write r9=0x12345678 -> with REGFILE_BYPASS_EN: 0x12345678 and rd_busy=0; without it: the old value and the registered busy bit.
REQ-037 Issue r3 and r4; then flush in the same cycle as an issue of r6 -> busy_vec is all 0 the next cycle; a write r3=0x5 in the flush cycle lands.
